// File: rtl/button_plant_pkg.sv
// Shared types and helpers for the NxM keypad scanner.
// Event records, scan states and pin polarity handling.
package button_plant_pkg;

    localparam int CODE_W = 6;

    function automatic int KEY_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        DWELL  = 2'd0,
        UPDATE = 2'd1,
        NEXT   = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic              press;
        logic [CODE_W-1:0] code;
    } key_evt_t;

    // Maps a raw pin level to 1 = active for either board polarity.
    function automatic logic to_active(input logic raw, input bit active_low);
        return raw ^ active_low;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through FIFO for keypad events.
// A push into a full FIFO succeeds only alongside a pop.
module key_event_fifo
    import button_plant_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  key_evt_t din,
    input  logic     pop,
    output key_evt_t dout,
    output logic     empty,
    output logic     full
);

    localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    key_evt_t        mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/button_plant_nxm_manager.sv
// NxM keypad scanner with per-key debounce, toggle state
// and a buffered press/release event stream.
module button_plant_nxm_manager
    import button_plant_pkg::*;
#(
    parameter int COLS           = 3,
    parameter int ROWS           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int ACTIVE_LOW     = 1,
    parameter int FIFO_DEPTH     = 4,
    localparam int KEYS          = ROWS * COLS,
    localparam int KW            = KEY_W(KEYS)
) (
    input  logic            aclk,
    input  logic            areset,
    output logic [COLS-1:0] O_BUTTON_COL,
    input  logic [ROWS-1:0] I_BUTTON_ROW,
    output logic [KEYS-1:0] o_key_push,
    output logic [KEYS-1:0] o_key_save,
    input  logic            i_save_clear,
    output logic            o_evt_valid,
    output logic [KW-1:0]   o_evt_code,
    output logic            o_evt_press,
    input  logic            i_evt_ready,
    output logic            o_evt_overflow
);

    localparam int  CW = KEY_W(COLS);
    localparam int  RW = KEY_W(ROWS);
    localparam int  DW = $clog2(SCAN_DIV);
    localparam bit  AL = (ACTIVE_LOW != 0);

    logic [ROWS-1:0] row_norm;
    logic [ROWS-1:0] sync1;
    logic [ROWS-1:0] sync2;
    logic [ROWS-1:0] snap;
    scan_state_t     state;
    logic [DW-1:0]   dwell_cnt;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [KEYS-1:0] push;
    logic [KEYS-1:0] save;
    logic [3:0]      db_cnt [KEYS];
    logic [KW-1:0]   key_idx;
    logic            row_bit;
    logic            key_state;
    logic            flip;
    logic            overflow;
    key_evt_t        evt_in;
    key_evt_t        evt_head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            evt_pop;
    logic            evt_unused;

    // Normalise row pins and drive the one-hot column strobe.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            row_norm[i] = to_active(I_BUTTON_ROW[i], AL);
        end
        for (int c = 0; c < COLS; c++) begin
            O_BUTTON_COL[c] = (col == CW'(c)) ^ AL;
        end
    end

    // Key under inspection this UPDATE cycle and its flip decision.
    always_comb begin
        key_idx      = KW'(int'(row) * COLS + int'(col));
        row_bit      = snap[row];
        key_state    = push[key_idx];
        flip         = (state == UPDATE) && (row_bit != key_state)
                       && (db_cnt[key_idx] == 4'(DEBOUNCE_SCANS - 1));
        evt_in.press = ~key_state;
        evt_in.code  = CODE_W'(key_idx);
    end

    // Two-flop synchroniser for the asynchronous row pins.
    always_ff @(posedge aclk) begin
        if (areset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= row_norm;
            sync2 <= sync1;
        end
    end

    // Scan sequencer: dwell on a column, walk its rows, advance.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= DWELL;
            dwell_cnt <= '0;
            row       <= '0;
            col       <= '0;
            snap      <= '0;
        end else begin
            unique case (state)
                DWELL: begin
                    if (dwell_cnt == DW'(SCAN_DIV - 1)) begin
                        dwell_cnt <= '0;
                        snap      <= sync2;
                        row       <= '0;
                        state     <= UPDATE;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                UPDATE: begin
                    if (row == RW'(ROWS - 1)) begin
                        row   <= '0;
                        state <= NEXT;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                NEXT: begin
                    col   <= (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
                    state <= DWELL;
                end
                default: state <= DWELL;
            endcase
        end
    end

    // Per-key debounce counters and debounced pressed state.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int k = 0; k < KEYS; k++) db_cnt[k] <= '0;
            push <= '0;
        end else if (state == UPDATE) begin
            if (row_bit == key_state) begin
                db_cnt[key_idx] <= '0;
            end else if (flip) begin
                db_cnt[key_idx] <= '0;
                push[key_idx]   <= ~key_state;
            end else begin
                db_cnt[key_idx] <= db_cnt[key_idx] + 4'd1;
            end
        end
    end

    // Toggle state flips on each debounced press; clear wins.
    always_ff @(posedge aclk) begin
        if (areset) begin
            save <= '0;
        end else if (i_save_clear) begin
            save <= '0;
        end else if (flip && !key_state) begin
            save[key_idx] <= ~save[key_idx];
        end
    end

    // Sticky flag for an event lost to a full FIFO.
    always_ff @(posedge aclk) begin
        if (areset) begin
            overflow <= 1'b0;
        end else if (flip && fifo_full && !evt_pop) begin
            overflow <= 1'b1;
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (flip),
        .din   (evt_in),
        .pop   (evt_pop),
        .dout  (evt_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign evt_pop        = o_evt_valid && i_evt_ready;
    assign o_evt_valid    = !fifo_empty;
    assign o_evt_code     = evt_head.code[KW-1:0];
    assign o_evt_press    = evt_head.press;
    assign o_evt_overflow = overflow;
    assign o_key_push     = push;
    assign o_key_save     = save;
    assign evt_unused     = ^evt_head.code;

endmodule

// File: tb/tb_button_plant_nxm_manager.sv
// Scoreboard bench for the NxM keypad scanner: a keypad model
// drives the rows, a monitor checks each accepted event.
module tb_button_plant_nxm_manager;

    localparam int COLS   = 3;
    localparam int ROWS   = 4;
    localparam int KEYS   = 12;
    localparam int FRAME  = 39;
    localparam int BUDGET = 200;

    logic             clk;
    logic             areset;
    logic [COLS-1:0]  col_out;
    logic [ROWS-1:0]  rows;
    logic [KEYS-1:0]  key_push;
    logic [KEYS-1:0]  key_save;
    logic             save_clear;
    logic             evt_valid;
    logic [3:0]       evt_code;
    logic             evt_press;
    logic             evt_ready;
    logic             evt_overflow;

    logic [KEYS-1:0]  pressed;
    logic [4:0]       exp_q [$];
    int               pop_cyc [$];
    logic [4:0]       e;
    logic [2:0]       seq [3];
    int               cyc;
    int               checks;
    int               errors;

    button_plant_nxm_manager #(
        .COLS           (3),
        .ROWS           (4),
        .SCAN_DIV       (8),
        .DEBOUNCE_SCANS (3),
        .ACTIVE_LOW     (1),
        .FIFO_DEPTH     (4)
    ) dut (
        .aclk           (clk),
        .areset         (areset),
        .O_BUTTON_COL   (col_out),
        .I_BUTTON_ROW   (rows),
        .o_key_push     (key_push),
        .o_key_save     (key_save),
        .i_save_clear   (save_clear),
        .o_evt_valid    (evt_valid),
        .o_evt_code     (evt_code),
        .o_evt_press    (evt_press),
        .i_evt_ready    (evt_ready),
        .o_evt_overflow (evt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: a held key pulls its row low while its column is active.
    always_comb begin
        rows = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (pressed[r*COLS + c] && col_out[c] == 1'b0) rows[r] = 1'b0;
            end
        end
    end

    // Monitor: every accepted event is matched against the scoreboard.
    always @(negedge clk) begin
        if (!areset && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected got press=%0d code=%0d want none",
                         evt_press, evt_code);
            end else begin
                e = exp_q.pop_front();
                if ({evt_press, evt_code} !== e) begin
                    errors++;
                    $display("FAIL evt_order got press=%0d code=%0d want press=%0d code=%0d",
                             evt_press, evt_code, e[4], e[3:0]);
                end
            end
            pop_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_push(input int k, input logic v);
        int n;
        n = 0;
        while (key_push[k] !== v && n < BUDGET) begin
            step(1);
            n++;
        end
        chk($sformatf("push%0d_reached_%0d", k, v), 32'(key_push[k]), 32'(v));
    endtask

    task automatic expect_key(input int k, input logic v);
        pressed[k] = v;
        exp_q.push_back({v, 4'(k)});
        wait_push(k, v);
        step(3);
        chk($sformatf("evt_drained_k%0d", k), exp_q.size(), 0);
    endtask

    initial begin
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        pressed    = '0;
        evt_ready  = 1'b1;
        save_clear = 1'b0;
        seq[0]     = 3'b110;
        seq[1]     = 3'b101;
        seq[2]     = 3'b011;
        areset     = 1'b1;
        step(2);
        chk("rst_col", col_out, 3'b110);
        chk("rst_push", key_push, 0);
        chk("rst_save", key_save, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_ovf", evt_overflow, 0);
        areset = 1'b0;

        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            chk($sformatf("col_seq_%0d", i), col_out, seq[(i / 13) % 3]);
        end
        step(1);

        expect_key(5, 1'b1);
        chk("save5_first_press", key_save[5], 1);
        expect_key(5, 1'b0);
        chk("save5_after_release", key_save[5], 1);
        expect_key(5, 1'b1);
        chk("save5_second_press", key_save[5], 0);
        expect_key(5, 1'b0);
        expect_key(5, 1'b1);
        chk("save5_third_press", key_save[5], 1);

        save_clear = 1'b1;
        step(1);
        save_clear = 1'b0;
        chk("save_cleared", key_save, 0);
        chk("push_after_clear", key_push, 12'h020);
        step(5);
        chk("no_evt_on_clear", evt_valid, 0);
        expect_key(5, 1'b0);

        for (int i = 0; i < 6; i++) begin
            pressed[5] = ~pressed[5];
            step(60);
        end
        step(4 * FRAME);
        chk("bounce_push", key_push, 0);
        chk("bounce_save", key_save, 0);
        chk("bounce_no_evt", exp_q.size(), 0);

        pop_cyc.delete();
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        exp_q.push_back({1'b1, 4'd0});
        exp_q.push_back({1'b1, 4'd3});
        wait_push(3, 1'b1);
        step(3);
        chk("pair_drained", exp_q.size(), 0);
        chk("pair_pops", pop_cyc.size(), 2);
        chk("pair_consecutive", pop_cyc[1] - pop_cyc[0], 1);
        pressed[0] = 1'b0;
        pressed[3] = 1'b0;
        exp_q.push_back({1'b0, 4'd0});
        exp_q.push_back({1'b0, 4'd3});
        wait_push(3, 1'b0);
        step(3);
        chk("pair_release_drained", exp_q.size(), 0);

        evt_ready  = 1'b0;
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        exp_q.push_back({1'b1, 4'd0});
        exp_q.push_back({1'b1, 4'd3});
        wait_push(3, 1'b1);
        pressed[0] = 1'b0;
        pressed[3] = 1'b0;
        exp_q.push_back({1'b0, 4'd0});
        exp_q.push_back({1'b0, 4'd3});
        wait_push(3, 1'b0);
        chk("ovf_not_yet", evt_overflow, 0);
        pressed[5] = 1'b1;
        wait_push(5, 1'b1);
        step(1);
        chk("ovf_set", evt_overflow, 1);
        chk("ovf_valid", evt_valid, 1);
        chk("ovf_push_vec", key_push, 12'h020);
        chk("ovf_head", {evt_press, evt_code}, {1'b1, 4'd0});
        pop_cyc.delete();
        evt_ready = 1'b1;
        step(10);
        chk("ovf_pop_count", pop_cyc.size(), 4);
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_valid_after", evt_valid, 0);
        chk("ovf_sticky", evt_overflow, 1);
        expect_key(5, 1'b0);
        chk("ovf_still_sticky", evt_overflow, 1);

        evt_ready  = 1'b0;
        pressed[7] = 1'b1;
        wait_push(7, 1'b1);
        step(2);
        chk("mid_valid", evt_valid, 1);
        areset = 1'b1;
        step(1);
        areset = 1'b0;
        chk("mid_rst_push", key_push, 0);
        chk("mid_rst_save", key_save, 0);
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_ovf", evt_overflow, 0);
        chk("mid_rst_col", col_out, 3'b110);
        evt_ready = 1'b1;
        exp_q.push_back({1'b1, 4'd7});
        wait_push(7, 1'b1);
        step(3);
        chk("mid_reemit", exp_q.size(), 0);
        chk("mid_save7", key_save, 12'h080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
